// File: rtl/mips_multicycle_processor.sv
// Multicycle MIPS subset core (FETCH/DECODE/EXECUTE/MEM/WB) on a req/ready bus,
// with a memory-mapped output port at IO_BASE and an input port at IO_BASE+4.
module mips_multicycle_processor #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          IN_WIDTH = 8,
  parameter logic [31:0] IO_BASE  = 32'h1001_0024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic [31:0]         ALUResultOut,
  output logic                retire,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ready
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                         FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_NOR = 6'h27,
                         FN_SLT = 6'h2A;

  state_t      state;
  logic [31:0] pc, ir, a, b, simm, mdr;
  logic [31:0] regs [0:31];
  logic        io_access;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, dest;
  logic [31:0] zimm, alu, next_pc, jump_target, port_in_ext;
  logic        writes, is_mem, is_link, is_store, io_hit;

  assign op          = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign shamt       = ir[10:6];
  assign funct       = ir[5:0];
  assign zimm        = {16'h0, ir[15:0]};
  assign jump_target = {pc[31:28], ir[25:0], 2'b00};
  assign dest        = (op == OP_RTYPE) ? rd : rt;
  assign is_store    = (op == OP_SW);
  assign io_hit      = is_store ? (alu == IO_BASE) : (alu == IO_BASE + 32'd4);

  always_comb begin
    port_in_ext                 = '0;
    port_in_ext[IN_WIDTH-1:0]   = PortIn;
  end

  // pc already holds PC+4 once the instruction has been fetched
  always_comb begin
    alu     = '0;
    writes  = 1'b0;
    is_mem  = 1'b0;
    is_link = 1'b0;
    next_pc = pc;
    case (op)
      OP_RTYPE: begin
        writes = 1'b1;
        case (funct)
          FN_ADD:  alu = a + b;
          FN_SUB:  alu = a - b;
          FN_AND:  alu = a & b;
          FN_OR:   alu = a | b;
          FN_NOR:  alu = ~(a | b);
          FN_SLT:  alu = {31'b0, $signed(a) < $signed(b)};
          FN_SLL:  alu = b << shamt;
          FN_SRL:  alu = b >> shamt;
          FN_JR: begin
            alu     = a;
            writes  = 1'b0;
            next_pc = a;
          end
          default: writes = 1'b0;
        endcase
      end
      OP_ADDI: begin alu = a + simm; writes = 1'b1; end
      OP_SLTI: begin alu = {31'b0, $signed(a) < $signed(simm)}; writes = 1'b1; end
      OP_ANDI: begin alu = a & zimm; writes = 1'b1; end
      OP_ORI:  begin alu = a | zimm; writes = 1'b1; end
      OP_LUI:  begin alu = {ir[15:0], 16'h0}; writes = 1'b1; end
      OP_LW, OP_SW: begin alu = a + simm; is_mem = 1'b1; end
      OP_BEQ: begin
        alu = a - b;
        if (a == b) next_pc = pc + (simm << 2);
      end
      OP_BNE: begin
        alu = a - b;
        if (a != b) next_pc = pc + (simm << 2);
      end
      OP_J:   begin alu = pc; next_pc = jump_target; end
      OP_JAL: begin alu = pc; next_pc = jump_target; is_link = 1'b1; end
      default: ;
    endcase
  end

  // Bus outputs are registered and set up on the transition into the requesting state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      simm         <= '0;
      mdr          <= '0;
      io_access    <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      PortOut      <= '0;
      ALUResultOut <= '0;
      retire       <= 1'b0;
      mem_req      <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= RESET_PC;
      mem_wdata    <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: if (mem_ready) begin
          ir      <= mem_rdata;
          pc      <= pc + 32'd4;
          mem_req <= 1'b0;
          state   <= DECODE;
        end
        DECODE: begin
          a     <= regs[rs];
          b     <= regs[rt];
          simm  <= {{16{ir[15]}}, ir[15:0]};
          state <= EXECUTE;
        end
        EXECUTE: begin
          ALUResultOut <= alu;
          if (is_mem) begin
            io_access <= io_hit;
            mem_req   <= !io_hit;
            mem_we    <= is_store && !io_hit;
            mem_addr  <= alu;
            mem_wdata <= b;
            state     <= MEM;
          end else if (writes) begin
            state <= WB;
          end else begin
            // control transfers and unsupported encodings complete here
            if (is_link) regs[31] <= pc;
            pc       <= next_pc;
            mem_req  <= 1'b1;
            mem_addr <= next_pc;
            retire   <= 1'b1;
            state    <= FETCH;
          end
        end
        MEM: if (io_access || mem_ready) begin
          if (is_store) begin
            if (io_access) PortOut <= b;
            retire   <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            state    <= FETCH;
          end else begin
            mdr     <= io_access ? port_in_ext : mem_rdata;
            mem_req <= 1'b0;
            state   <= WB;
          end
        end
        WB: begin
          if (dest != 5'd0) regs[dest] <= (op == OP_LW) ? mdr : ALUResultOut;
          retire   <= 1'b1;
          mem_req  <= 1'b1;
          mem_addr <= pc;
          state    <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_processor.sv
// Bench for mips_multicycle_processor: small programs in a bus memory model, with
// expected retirements queued per program and popped as retire pulses appear.
module tb_mips_multicycle_processor;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] IO_BASE  = 32'h1001_0024;
  localparam int          IN_WIDTH = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [IN_WIDTH-1:0] port_in;
  logic [31:0]         port_out, alu_result_out, mem_addr, mem_wdata, mem_rdata;
  logic                retire, mem_req, mem_we, mem_ready;

  mips_multicycle_processor #(.RESET_PC(RESET_PC), .IN_WIDTH(IN_WIDTH), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .reset(reset), .PortIn(port_in), .PortOut(port_out),
    .ALUResultOut(alu_result_out), .retire(retire), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    bit          chk_alu;
    int          lat;
    logic [31:0] next_pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [0:255];
  int          n_compared = 0, n_mismatched = 0;
  int          wait_states = 0, wait_cnt = 0, unstable_cnt = 0, io_req_cnt = 0;
  logic [31:0] held_addr, held_wdata;
  logic        held_we;

  // Code (0x004x_xxxx) and data (0x100x_xxxx) regions share one small array
  function automatic logic [7:0] widx(input logic [31:0] addr);
    return {addr[28], addr[8:2]};
  endfunction

  assign mem_rdata = mem[widx(mem_addr)];

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [31:0] addr);
    return {op, addr[27:2]};
  endfunction

  task automatic expect_retire(input logic [31:0] alu, input bit chk, input int lat,
                               input logic [31:0] npc);
    exp_q.push_back('{alu: alu, chk_alu: chk, lat: lat, next_pc: npc});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  // Decides mem_ready for the coming edge; stores commit on the accepting edge
  task automatic drive_ready();
    if (!mem_req) begin
      mem_ready = 1'b1;
      wait_cnt  = 0;
    end else begin
      if (wait_cnt == 0) begin
        held_addr  = mem_addr;
        held_we    = mem_we;
        held_wdata = mem_wdata;
      end else if (mem_addr !== held_addr || mem_we !== held_we || mem_wdata !== held_wdata) begin
        unstable_cnt++;
      end
      if (wait_cnt < wait_states) begin
        mem_ready = 1'b0;
        wait_cnt++;
      end else begin
        if (mem_we) mem[widx(mem_addr)] = mem_wdata;
        mem_ready = 1'b1;
        wait_cnt  = 0;
      end
    end
  endtask

  task automatic start_program();
    reset     = 1'b0;
    mem_ready = 1'b1;
    wait_cnt  = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive_ready();
  endtask

  task automatic run_program(input int max_cycles);
    exp_t e;
    int   cyc;
    int   last;
    cyc  = 0;
    last = 0;
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      if (mem_req && (mem_addr == IO_BASE || mem_addr == IO_BASE + 32'd4)) io_req_cnt++;
      if (retire) begin
        e = exp_q.pop_front();
        n_compared++;
        if (cyc - last !== e.lat) begin
          n_mismatched++;
          $display("[TB] FAIL latency: got %0d cycles, expected %0d", cyc - last, e.lat);
        end
        last = cyc;
        n_compared++;
        if (mem_req !== 1'b1 || mem_addr !== e.next_pc) begin
          n_mismatched++;
          $display("[TB] FAIL next_fetch: got req=%b addr=%h, expected req=1 addr=%h",
                   mem_req, mem_addr, e.next_pc);
        end
        if (e.chk_alu) begin
          n_compared++;
          if (alu_result_out !== e.alu) begin
            n_mismatched++;
            $display("[TB] FAIL alu_result: got %h, expected %h", alu_result_out, e.alu);
          end
        end
      end
      drive_ready();
    end
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL retire_timeout: %0d retirements outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reg(input string name, input int r, input logic [31:0] exp);
    n_compared++;
    if (dut.regs[r] !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, dut.regs[r], exp);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset     = 1'b0;
    mem_ready = 1'b1;
    port_in   = '0;
    repeat (3) @(negedge clk);
    n_compared += 6;
    if (mem_req !== 1'b1)        begin n_mismatched++; $display("[TB] FAIL rst_req: got %b, expected 1", mem_req); end
    if (mem_addr !== RESET_PC)   begin n_mismatched++; $display("[TB] FAIL rst_addr: got %h, expected %h", mem_addr, RESET_PC); end
    if (mem_we !== 1'b0)         begin n_mismatched++; $display("[TB] FAIL rst_we: got %b, expected 0", mem_we); end
    if (retire !== 1'b0)         begin n_mismatched++; $display("[TB] FAIL rst_retire: got %b, expected 0", retire); end
    if (port_out !== 32'h0)      begin n_mismatched++; $display("[TB] FAIL rst_portout: got %h, expected 0", port_out); end
    if (alu_result_out !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_alu: got %h, expected 0", alu_result_out); end
  endtask

  task automatic test_arith();
    $display("[TB] test_arith");
    clear_mem();
    mem[0] = itype(6'h08, 0, 8, 16'h0005);
    mem[1] = itype(6'h08, 0, 9, 16'hFFFD);
    mem[2] = rtype(8, 9, 10, 0, 6'h20);
    expect_retire(32'h0000_0005, 1, 4, RESET_PC + 32'd4);
    expect_retire(32'hFFFF_FFFD, 1, 4, RESET_PC + 32'd8);
    expect_retire(32'h0000_0002, 1, 4, RESET_PC + 32'd12);
    start_program();
    run_program(100);
    check_reg("arith_r10", 10, 32'h2);
  endtask

  task automatic test_alu_ops();
    logic [31:0] code [17];
    logic [31:0] res  [17];
    int          lat  [17];
    $display("[TB] test_alu_ops");
    code[0]  = itype(6'h08, 0, 8, 16'hFFFD);   res[0]  = 32'hFFFF_FFFD; lat[0]  = 4;
    code[1]  = itype(6'h08, 0, 9, 16'h0006);   res[1]  = 32'h0000_0006; lat[1]  = 4;
    code[2]  = rtype(9, 8, 10, 0, 6'h22);      res[2]  = 32'h0000_0009; lat[2]  = 4;
    code[3]  = rtype(8, 9, 11, 0, 6'h24);      res[3]  = 32'h0000_0004; lat[3]  = 4;
    code[4]  = rtype(8, 9, 12, 0, 6'h25);      res[4]  = 32'hFFFF_FFFF; lat[4]  = 4;
    code[5]  = rtype(8, 9, 13, 0, 6'h27);      res[5]  = 32'h0000_0000; lat[5]  = 4;
    code[6]  = rtype(8, 9, 14, 0, 6'h2A);      res[6]  = 32'h0000_0001; lat[6]  = 4;
    code[7]  = rtype(0, 9, 15, 4, 6'h00);      res[7]  = 32'h0000_0060; lat[7]  = 4;
    code[8]  = rtype(0, 8, 16, 28, 6'h02);     res[8]  = 32'h0000_000F; lat[8]  = 4;
    code[9]  = itype(6'h0C, 8, 17, 16'hFFF0);  res[9]  = 32'h0000_FFF0; lat[9]  = 4;
    code[10] = itype(6'h0A, 8, 18, 16'hFFFE);  res[10] = 32'h0000_0001; lat[10] = 4;
    code[11] = itype(6'h3F, 0, 20, 16'h1234);  res[11] = 32'h0;         lat[11] = 3;
    code[12] = rtype(8, 9, 21, 0, 6'h3F);      res[12] = 32'h0;         lat[12] = 3;
    code[13] = itype(6'h08, 0, 0, 16'h0009);   res[13] = 32'h0000_0009; lat[13] = 4;
    code[14] = rtype(0, 0, 19, 0, 6'h20);      res[14] = 32'h0000_0000; lat[14] = 4;
    code[15] = rtype(9, 8, 22, 0, 6'h2A);      res[15] = 32'h0000_0000; lat[15] = 4;
    code[16] = itype(6'h0D, 9, 23, 16'h8001);  res[16] = 32'h0000_8007; lat[16] = 4;
    clear_mem();
    for (int i = 0; i < 17; i++) begin
      mem[i] = code[i];
      expect_retire(res[i], lat[i] == 4, lat[i], RESET_PC + 32'(4 * i + 4));
    end
    start_program();
    run_program(400);
    check_reg("r0_zero", 0, 32'h0);
    check_reg("sub_r10", 10, 32'h9);
    check_reg("srl_r16", 16, 32'hF);
    check_reg("nop_op_r20", 20, 32'h0);
    check_reg("nop_fn_r21", 21, 32'h0);
    check_reg("ori_r23", 23, 32'h8007);
  endtask

  task automatic test_io();
    $display("[TB] test_io");
    clear_mem();
    port_in = 8'h3C;
    mem[0] = itype(6'h0F, 0, 8, 16'h1001);
    mem[1] = itype(6'h0D, 8, 8, 16'h0024);
    mem[2] = itype(6'h08, 0, 9, 16'h00A5);
    mem[3] = itype(6'h2B, 8, 9, 16'h0000);
    mem[4] = itype(6'h23, 8, 10, 16'h0004);
    expect_retire(32'h1001_0000, 1, 4, RESET_PC + 32'd4);
    expect_retire(32'h1001_0024, 1, 4, RESET_PC + 32'd8);
    expect_retire(32'h0000_00A5, 1, 4, RESET_PC + 32'd12);
    expect_retire(32'h1001_0024, 1, 4, RESET_PC + 32'd16);
    expect_retire(32'h1001_0028, 1, 5, RESET_PC + 32'd20);
    io_req_cnt = 0;
    start_program();
    run_program(100);
    n_compared += 2;
    if (port_out !== 32'h0000_00A5) begin n_mismatched++; $display("[TB] FAIL portout: got %h, expected 000000a5", port_out); end
    if (io_req_cnt !== 0) begin n_mismatched++; $display("[TB] FAIL io_no_req: got %0d bus cycles, expected 0", io_req_cnt); end
    check_reg("portin_r10", 10, 32'h0000_003C);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_compared++;
    if (port_out !== 32'h0) begin n_mismatched++; $display("[TB] FAIL portout_reset: got %h, expected 0", port_out); end
  endtask

  task automatic test_memory();
    $display("[TB] test_memory");
    clear_mem();
    mem[0] = itype(6'h0F, 0, 9, 16'h1001);
    mem[1] = itype(6'h08, 0, 8, 16'h1234);
    mem[2] = itype(6'h2B, 9, 8, 16'h0008);
    mem[3] = itype(6'h23, 9, 10, 16'h0008);
    expect_retire(32'h1001_0000, 1, 5, RESET_PC + 32'd4);
    expect_retire(32'h0000_1234, 1, 5, RESET_PC + 32'd8);
    expect_retire(32'h1001_0008, 1, 6, RESET_PC + 32'd12);
    expect_retire(32'h1001_0008, 1, 7, RESET_PC + 32'd16);
    wait_states  = 1;
    unstable_cnt = 0;
    start_program();
    run_program(100);
    wait_states = 0;
    n_compared += 2;
    if (mem[widx(32'h1001_0008)] !== 32'h0000_1234) begin
      n_mismatched++;
      $display("[TB] FAIL store_data: got %h, expected 00001234", mem[widx(32'h1001_0008)]);
    end
    if (unstable_cnt !== 0) begin n_mismatched++; $display("[TB] FAIL bus_hold: got %0d changes, expected 0", unstable_cnt); end
    check_reg("load_r10", 10, 32'h0000_1234);
  endtask

  task automatic test_branch();
    $display("[TB] test_branch");
    clear_mem();
    mem[0] = itype(6'h08, 0, 8, 16'h0001);
    mem[1] = itype(6'h04, 8, 0, 16'h0005);
    mem[2] = itype(6'h05, 8, 0, 16'h0004);
    mem[7] = itype(6'h05, 0, 0, 16'h0004);
    mem[8] = itype(6'h04, 0, 0, 16'hFFFF);
    expect_retire(32'h1, 1, 4, RESET_PC + 32'h04);
    expect_retire(32'h0, 0, 3, RESET_PC + 32'h08);
    expect_retire(32'h0, 0, 3, RESET_PC + 32'h1C);
    expect_retire(32'h0, 0, 3, RESET_PC + 32'h20);
    expect_retire(32'h0, 0, 3, RESET_PC + 32'h20);
    expect_retire(32'h0, 0, 3, RESET_PC + 32'h20);
    start_program();
    run_program(100);
  endtask

  task automatic test_jump();
    $display("[TB] test_jump");
    clear_mem();
    mem[0]  = jtype(6'h02, 32'h0040_0010);
    mem[4]  = jtype(6'h03, 32'h0040_0040);
    mem[5]  = itype(6'h08, 0, 2, 16'h0007);
    mem[16] = rtype(31, 0, 0, 0, 6'h08);
    expect_retire(32'h0, 0, 3, 32'h0040_0010);
    expect_retire(32'h0, 0, 3, 32'h0040_0040);
    expect_retire(32'h0, 0, 3, 32'h0040_0014);
    expect_retire(32'h7, 1, 4, 32'h0040_0018);
    start_program();
    run_program(100);
    check_reg("jal_r31", 31, 32'h0040_0014);
  endtask

  task automatic test_reset_abort();
    $display("[TB] test_reset_abort");
    clear_mem();
    mem[0] = itype(6'h08, 0, 10, 16'h0007);
    mem[1] = itype(6'h23, 0, 10, 16'h0000);
    expect_retire(32'h7, 1, 4, RESET_PC + 32'd4);
    start_program();
    run_program(50);
    mem_ready = 1'b0;
    @(negedge clk);
    n_compared++;
    if (mem_addr !== RESET_PC + 32'd4) begin n_mismatched++; $display("[TB] FAIL stall_addr: got %h, expected %h", mem_addr, RESET_PC + 32'd4); end
    reset     = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b0;
    n_compared += 3;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
      n_mismatched++;
      $display("[TB] FAIL abort_fetch: got req=%b addr=%h, expected req=1 addr=%h", mem_req, mem_addr, RESET_PC);
    end
    if (retire !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_retire: got %b, expected 0", retire); end
    if (alu_result_out !== 32'h0) begin n_mismatched++; $display("[TB] FAIL abort_alu: got %h, expected 0", alu_result_out); end
    check_reg("abort_r10", 10, 32'h0);
    @(negedge clk);
    n_compared++;
    if (mem_addr !== RESET_PC) begin n_mismatched++; $display("[TB] FAIL abort_hold: got %h, expected %h", mem_addr, RESET_PC); end
    mem_ready = 1'b1;
    expect_retire(32'h7, 1, 4, RESET_PC + 32'd4);
    run_program(50);
    check_reg("restart_r10", 10, 32'h7);
  endtask

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b1;
    port_in   = '0;
    clear_mem();
    test_reset();
    test_arith();
    test_alu_ops();
    test_io();
    test_memory();
    test_branch();
    test_jump();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_processor.md
MIPS_MULTICYCLE_PROCESSOR -- requirements
Module: mips_multicycle_processor

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, SHALL set the PC value loaded at reset.
REQ-002 Parameter IN_WIDTH, default 8, SHALL set the PortIn width (1..32).
REQ-003 Parameter IO_BASE, default 32'h1001_0024, SHALL be the PortOut address; IO_BASE+4 SHALL be the PortIn address.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-006 PortIn  input  IN_WIDTH  SHALL be the memory-mapped input port.
REQ-007 PortOut  output  32  SHALL be the registered memory-mapped output port.
REQ-008 ALUResultOut  output  32  SHALL be the registered result of the last EXECUTE cycle.
REQ-009 retire  output  1  SHALL pulse high for one cycle when an instruction completes.
REQ-010 mem_req, mem_we  output  1 each  SHALL form the bus request and write strobe.
REQ-011 mem_addr, mem_wdata  output  32 each  SHALL carry the bus word address and store data.
REQ-012 mem_rdata  input  32, mem_ready  input  1  SHALL carry the bus read data and transfer acknowledge.

Function
REQ-013 The FSM SHALL have states FETCH, DECODE, EXECUTE, MEM, WB.
REQ-014 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on the edge with mem_ready=1, latch IR, PC<=PC+4, go DECODE.
REQ-015 DECODE: latch A=R[rs], B=R[rt], sign-extended imm; go EXECUTE.
REQ-016 EXECUTE: compute ALU, latch ALUResultOut; beq/bne/j/jal/jr resolve here, retire, go FETCH; lw/sw go MEM; others go WB.
REQ-017 Supported: add, sub, and, or, nor, slt, sll, srl, jr (R-type); addi, andi, ori, lui, slti, lw, sw, beq, bne, j, jal.
REQ-018 addi/slti/lw/sw/beq/bne SHALL sign-extend imm; andi/ori SHALL zero-extend; lui SHALL produce {imm,16'h0}; arithmetic wraps modulo 2^32, no overflow trap.
REQ-019 Branch target SHALL be PC+4+(simm<<2); jump target {PC+4[31:28],target,2'b00}; jr SHALL load R[rs]; jal SHALL write PC+4 to R31.
REQ-020 MEM: address equal to IO_BASE (sw) SHALL update PortOut and IO_BASE+4 (lw) SHALL return zero-extended PortIn, both in one cycle without mem_req.
REQ-021 MEM otherwise: mem_req=1, mem_we=1 for sw; hold mem_addr, mem_wdata, mem_we stable until the mem_ready edge; lw captures mem_rdata on that edge.
REQ-022 WB: write rd (R-type), rt (I-type/lw); retire; go FETCH.
REQ-023 Writes to R0 SHALL be discarded; R0 SHALL read 0.
REQ-024 Unsupported opcode/funct SHALL execute as NOP: no register/memory/port write, retire in EXECUTE.
REQ-025 mem_req SHALL be 0 in DECODE, EXECUTE, WB; a mem_ready while mem_req=0 SHALL be ignored.
REQ-026 Latency with mem_ready tied 1: branch/jump 3 cycles, R/I-type 4, sw 4, lw 5; each wait cycle adds one.

Reset
REQ-027 reset=0 at a rising edge SHALL set PC=RESET_PC, R0..R31=0, state FETCH, PortOut=0, ALUResultOut=0, retire=0.
REQ-028 Reset SHALL take priority over any pending bus transfer; mem_req SHALL be 1 with mem_addr=RESET_PC in the first cycle after reset releases.
REQ-029 An aborted transfer SHALL not write any register or PortOut.

Verification
REQ-030 addi $8,$0,5; addi $9,$0,-3; add $10,$8,$9 -> $10=2, ALUResultOut=2, retire pulses at cycles 4, 8, 12.
REQ-031 lui $8,0x1001; ori $8,$8,0x24; addi $9,$0,0xA5; sw $9,0($8) -> PortOut=0xA5, no mem_req in MEM.
REQ-032 PortIn=8'h3C; lw $10,4($8) ($8=IO_BASE) -> $10=0x3C, latency 5 cycles.
REQ-033 beq $0,$0,-1 -> PC returns to same address every 3 cycles; bne $0,$0,+4 -> PC+4.
REQ-034 jal at 0x0040_0010 to 0x0040_0040 then jr $31 -> $31=0x0040_0014, PC=0x0040_0014.
REQ-035 mem_ready held 0 for 3 cycles during lw fetch, reset=0 asserted on cycle 2 -> no register change, next mem_addr=RESET_PC.
